// File: rtl/ula_sequenciador.sv
// rtl/ula_sequenciador.sv - fetch/decode/writeback sequencer driving an external 8-bit ALU
module ula_sequenciador #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  output logic            instr_rd_en,
  input  logic [15:0]     instr_data,
  output logic [7:0]      alu_temp1,
  output logic [7:0]      alu_temp2,
  output logic [4:0]      alu_seletor,
  input  logic [7:0]      alu_saida,
  input  logic            alu_carry,
  output logic            busy,
  output logic            halted,
  output logic            carry_flag,
  output logic            div_zero,
  input  logic [1:0]      dbg_sel,
  output logic [7:0]      dbg_data
);

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_MOV  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [7:0]      rf [4];

  logic [4:0] op;
  logic [1:0] rd, rs, rt;
  logic [7:0] imm8;
  logic       is_alu;
  logic       start_ok;

  assign op     = ir[15:11];
  assign rd     = ir[10:9];
  assign rs     = ir[8:7];
  assign rt     = ir[6:5];
  assign imm8   = ir[7:0];
  assign is_alu = (op >= OP_ADD) && (op <= OP_NOT);

  // start is only honoured from the quiet states; a pulse mid-program is dropped
  assign start_ok = start && ((state == S_IDLE) || (state == S_HALT));

  assign instr_addr = pc;
  assign dbg_data   = rf[dbg_sel];

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // next-state and status outputs
  always_comb begin
    state_next  = state;
    instr_rd_en = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_next = S_FETCH;
      end
      S_FETCH: begin
        instr_rd_en = 1'b1;
        state_next  = S_WAIT;
      end
      S_WAIT: state_next = S_EXEC;
      S_EXEC: state_next = (op == OP_HALT) ? S_HALT : S_WB;
      S_WB:   state_next = S_FETCH;
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start_ok) state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // datapath: PC, IR, ALU operand registers, register file and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ir          <= 16'h0000;
      alu_temp1   <= 8'h00;
      alu_temp2   <= 8'h00;
      alu_seletor <= 5'b00000;
      carry_flag  <= 1'b0;
      div_zero    <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start_ok) begin
            pc         <= RESET_PC;
            carry_flag <= 1'b0;
            div_zero   <= 1'b0;
          end
        end
        S_WAIT: ir <= instr_data;
        S_EXEC: begin
          // operands are captured here so rd may alias rs/rt safely
          if (is_alu) begin
            alu_temp1   <= rf[rs];
            alu_temp2   <= rf[rt];
            alu_seletor <= op;
          end
        end
        S_WB: begin
          if (op == OP_LDI) begin
            rf[rd] <= imm8;
          end else if (op == OP_MOV) begin
            rf[rd] <= rf[rs];
          end else if (is_alu) begin
            if ((op == OP_DIV) && (alu_temp2 == 8'h00)) begin
              // divide by zero: saturate result, ignore whatever the ALU returns
              rf[rd]   <= 8'hFF;
              div_zero <= 1'b1;
            end else begin
              rf[rd] <= alu_saida;
            end
            if ((op == OP_ADD) || (op == OP_MUL)) carry_flag <= alu_carry;
          end
          pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequenciador.sv
// tb/tb_ula_sequenciador.sv - directed self-checking bench for ula_sequenciador
module tb_ula_sequenciador;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  instr_addr;
  logic        instr_rd_en;
  logic [15:0] instr_data;
  logic [7:0]  alu_temp1, alu_temp2;
  logic [4:0]  alu_seletor;
  logic [7:0]  alu_saida;
  logic        alu_carry;
  logic        busy, halted, carry_flag, div_zero;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  logic [15:0] rom [256];
  int vectors = 0;
  int miscompares = 0;

  ula_sequenciador #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start),
    .instr_addr(instr_addr), .instr_rd_en(instr_rd_en), .instr_data(instr_data),
    .alu_temp1(alu_temp1), .alu_temp2(alu_temp2), .alu_seletor(alu_seletor),
    .alu_saida(alu_saida), .alu_carry(alu_carry),
    .busy(busy), .halted(halted), .carry_flag(carry_flag), .div_zero(div_zero),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // synchronous instruction ROM: data one cycle after the read strobe
  always @(posedge clk) if (instr_rd_en) instr_data <= rom[instr_addr];

  // reference ALU
  always_comb begin
    logic [8:0]  s;
    logic [15:0] p;
    s = 9'h000;
    p = 16'h0000;
    alu_saida = 8'h00;
    alu_carry = 1'b0;
    case (alu_seletor)
      5'b00100: begin s = {1'b0, alu_temp1} + {1'b0, alu_temp2}; alu_saida = s[7:0]; alu_carry = s[8]; end
      5'b00101: alu_saida = alu_temp1 - alu_temp2;
      5'b00110: begin p = alu_temp1 * alu_temp2; alu_saida = p[7:0]; alu_carry = (p[15:8] != 8'h00); end
      5'b00111: alu_saida = (alu_temp2 == 8'h00) ? 8'h00 : alu_temp1 / alu_temp2;
      5'b01000: alu_saida = alu_temp1 & alu_temp2;
      5'b01001: alu_saida = ~(alu_temp1 & alu_temp2);
      5'b01010: alu_saida = alu_temp1 | alu_temp2;
      5'b01011: alu_saida = alu_temp1 ^ alu_temp2;
      5'b01100: alu_saida = (alu_temp1 < alu_temp2) ? 8'hFF : ((alu_temp1 > alu_temp2) ? 8'h01 : 8'h00);
      5'b01101: alu_saida = ~alu_temp1;
      default:  alu_saida = 8'h00;
    endcase
  end

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt, 5'b00000};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {5'b00001, rd, 1'b0, imm};
  endfunction

  localparam logic [15:0] HALT_W = 16'hF800;

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
    dbg_sel = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!halted) begin
      miscompares++;
      $display("FAIL %s halt_timeout: halted=%0b required 1", name, halted);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    vectors++;
    if ({busy, halted, instr_rd_en, carry_flag, div_zero} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_status: busy/halted/rd_en/carry/dz=%b required 00000", {busy, halted, instr_rd_en, carry_flag, div_zero});
    end
    vectors++;
    if ({alu_temp1, alu_temp2, alu_seletor, instr_addr} !== 29'h0) begin
      miscompares++;
      $display("FAIL reset_alu_pc: t1=%h t2=%h sel=%b pc=%h required all zero", alu_temp1, alu_temp2, alu_seletor, instr_addr);
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      vectors++;
      if (v !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_reg R%0d: got %h required 00", i, v);
      end
    end
  endtask

  task automatic test_basic_add();
    logic [7:0] v;
    clear_rom();
    rom[0] = ldi(2'd0, 8'h05);
    rom[1] = ldi(2'd1, 8'h03);
    rom[2] = ins(5'b00100, 2'd2, 2'd0, 2'd1);
    rom[3] = HALT_W;
    do_reset();
    pulse_start();
    vectors++;
    if (!(instr_rd_en === 1'b1 && instr_addr === 8'h00 && busy === 1'b1)) begin
      miscompares++;
      $display("FAIL first_fetch: rd_en=%b addr=%h busy=%b required 1 00 1", instr_rd_en, instr_addr, busy);
    end
    repeat (3) @(negedge clk);
    read_reg(2'd0, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("FAIL wb_cycle_R0: got %h required 00", v);
    end
    @(negedge clk);
    read_reg(2'd0, v);
    vectors++;
    if (v !== 8'h05) begin
      miscompares++;
      $display("FAIL after_wb_R0: got %h required 05", v);
    end
    wait_halt("basic_add");
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h08) begin
      miscompares++;
      $display("FAIL add_R2: got %h required 08", v);
    end
    vectors++;
    if ({carry_flag, busy, instr_addr} !== {1'b0, 1'b0, 8'h03}) begin
      miscompares++;
      $display("FAIL halt_state: carry=%b busy=%b pc=%h required 0 0 03", carry_flag, busy, instr_addr);
    end
  endtask

  task automatic test_carry();
    logic [7:0] v;
    clear_rom();
    rom[0] = ldi(2'd0, 8'hC8);
    rom[1] = ldi(2'd1, 8'h64);
    rom[2] = ins(5'b00100, 2'd2, 2'd0, 2'd1);
    rom[3] = ins(5'b00110, 2'd3, 2'd1, 2'd1);
    rom[4] = ins(5'b00010, 2'd0, 2'd3, 2'd0);
    rom[5] = ins(5'b01000, 2'd3, 2'd2, 2'd1);
    rom[6] = HALT_W;
    do_reset();
    pulse_start();
    wait_halt("carry");
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h2C) begin
      miscompares++;
      $display("FAIL add_carry_R2: got %h required 2C", v);
    end
    read_reg(2'd0, v);
    vectors++;
    if (v !== 8'h10) begin
      miscompares++;
      $display("FAIL mul_R3_via_mov: got %h required 10", v);
    end
    read_reg(2'd3, v);
    vectors++;
    if (v !== 8'h24) begin
      miscompares++;
      $display("FAIL and_R3: got %h required 24", v);
    end
    vectors++;
    if (carry_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL carry_kept: got %b required 1", carry_flag);
    end
    clear_rom();
    rom[0] = ldi(2'd0, 8'hC8);
    rom[1] = ldi(2'd1, 8'h64);
    rom[2] = ins(5'b01000, 2'd3, 2'd0, 2'd1);
    rom[3] = HALT_W;
    do_reset();
    pulse_start();
    wait_halt("and");
    read_reg(2'd3, v);
    vectors++;
    if (v !== 8'h40) begin
      miscompares++;
      $display("FAIL and_C8_64: got %h required 40", v);
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] v;
    clear_rom();
    rom[0] = ldi(2'd0, 8'h10);
    rom[1] = ldi(2'd1, 8'h00);
    rom[2] = ins(5'b00111, 2'd2, 2'd0, 2'd1);
    rom[3] = ins(5'b00010, 2'd3, 2'd2, 2'd0);
    rom[4] = ldi(2'd1, 8'h04);
    rom[5] = ins(5'b00111, 2'd2, 2'd0, 2'd1);
    rom[6] = HALT_W;
    do_reset();
    pulse_start();
    wait_halt("div");
    read_reg(2'd3, v);
    vectors++;
    if (v !== 8'hFF) begin
      miscompares++;
      $display("FAIL div0_result: got %h required FF", v);
    end
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h04) begin
      miscompares++;
      $display("FAIL div_10_4: got %h required 04", v);
    end
    vectors++;
    if ({div_zero, carry_flag} !== 2'b10) begin
      miscompares++;
      $display("FAIL div_flags: dz/carry=%b required 10", {div_zero, carry_flag});
    end
    rom[0] = HALT_W;
    pulse_start();
    vectors++;
    if (div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_clear_on_start: got %b required 0", div_zero);
    end
    wait_halt("restart");
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h04) begin
      miscompares++;
      $display("FAIL restart_keeps_regs: got %h required 04", v);
    end
  endtask

  task automatic test_cmp_not_sub();
    logic [7:0] v;
    clear_rom();
    rom[0] = ldi(2'd0, 8'h03);
    rom[1] = ldi(2'd1, 8'h07);
    rom[2] = ins(5'b01100, 2'd2, 2'd0, 2'd1);
    rom[3] = ins(5'b01100, 2'd3, 2'd1, 2'd0);
    rom[4] = HALT_W;
    do_reset();
    pulse_start();
    wait_halt("cmp");
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'hFF) begin
      miscompares++;
      $display("FAIL cmp_3_7: got %h required FF", v);
    end
    read_reg(2'd3, v);
    vectors++;
    if (v !== 8'h01) begin
      miscompares++;
      $display("FAIL cmp_7_3: got %h required 01", v);
    end
    clear_rom();
    rom[0] = ldi(2'd0, 8'h07);
    rom[1] = ins(5'b01100, 2'd1, 2'd0, 2'd0);
    rom[2] = ldi(2'd0, 8'h0F);
    rom[3] = ldi(2'd3, 8'hAA);
    rom[4] = ins(5'b01101, 2'd2, 2'd0, 2'd3);
    rom[5] = ldi(2'd3, 8'h05);
    rom[6] = ldi(2'd0, 8'h03);
    rom[7] = ins(5'b00101, 2'd3, 2'd0, 2'd3);
    rom[8] = HALT_W;
    do_reset();
    pulse_start();
    wait_halt("not_sub");
    read_reg(2'd1, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("FAIL cmp_7_7: got %h required 00", v);
    end
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'hF0) begin
      miscompares++;
      $display("FAIL not_0F: got %h required F0", v);
    end
    read_reg(2'd3, v);
    vectors++;
    if (v !== 8'hFE) begin
      miscompares++;
      $display("FAIL sub_3_5: got %h required FE", v);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [7:0] v;
    int n;
    clear_rom();
    rom[0] = ldi(2'd2, 8'h11);
    rom[1] = ldi(2'd0, 8'h01);
    rom[2] = ldi(2'd1, 8'h02);
    rom[3] = ins(5'b00100, 2'd2, 2'd0, 2'd1);
    rom[4] = HALT_W;
    do_reset();
    pulse_start();
    n = 0;
    while (!(instr_rd_en && instr_addr == 8'h03) && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(instr_rd_en && instr_addr == 8'h03)) begin
      miscompares++;
      $display("FAIL reach_fetch3: addr=%h rd_en=%b required 03 1", instr_addr, instr_rd_en);
    end
    repeat (2) @(negedge clk);
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h11) begin
      miscompares++;
      $display("FAIL pre_reset_R2: got %h required 11", v);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    read_reg(2'd2, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("FAIL aborted_R2: got %h required 00", v);
    end
    vectors++;
    if ({busy, instr_rd_en, halted, alu_seletor, instr_addr} !== 16'h0000) begin
      miscompares++;
      $display("FAIL aborted_state: busy=%b rd_en=%b halted=%b sel=%b pc=%h required all zero", busy, instr_rd_en, halted, alu_seletor, instr_addr);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, instr_rd_en} !== 2'b00) begin
      miscompares++;
      $display("FAIL stays_idle: busy/rd_en=%b required 00", {busy, instr_rd_en});
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    clear_rom();
    do_reset();
    pulse_start();
    repeat (4) @(negedge clk);
    vectors++;
    if (!(instr_rd_en === 1'b1 && instr_addr === 8'h01)) begin
      miscompares++;
      $display("FAIL fetch1: addr=%h rd_en=%b required 01 1", instr_addr, instr_rd_en);
    end
    pulse_start();
    n = 0;
    while (!instr_rd_en && n < 8) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(instr_rd_en === 1'b1 && instr_addr === 8'h02)) begin
      miscompares++;
      $display("FAIL start_ignored_busy: addr=%h rd_en=%b required 02 1", instr_addr, instr_rd_en);
    end
  endtask

  task automatic test_pc_wrap();
    logic [7:0] v;
    int n;
    clear_rom();
    rom[5] = {5'b10101, 2'd1, 9'h1AB};
    do_reset();
    pulse_start();
    n = 0;
    while (!(instr_rd_en && instr_addr == 8'hFF) && n < 1200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(instr_rd_en && instr_addr == 8'hFF)) begin
      miscompares++;
      $display("FAIL reach_ff: addr=%h rd_en=%b required FF 1", instr_addr, instr_rd_en);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (!(instr_rd_en === 1'b1 && instr_addr === 8'h00 && busy === 1'b1)) begin
      miscompares++;
      $display("FAIL pc_wrap: addr=%h rd_en=%b busy=%b required 00 1 1", instr_addr, instr_rd_en, busy);
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      vectors++;
      if (v !== 8'h00) begin
        miscompares++;
        $display("FAIL undefined_op_R%0d: got %h required 00", i, v);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    dbg_sel = 2'd0;
    clear_rom();
    test_reset();
    test_basic_add();
    test_carry();
    test_div_zero();
    test_cmp_not_sub();
    test_reset_mid_exec();
    test_start_while_busy();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
